serv_wb_arbiter: RTL and testbench
==================================

SERV_WB_ARBITER -- requirements
Module: serv_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 8, watchdog counter width in bits (used only with SERV_ARB_TIMEOUT_EN).
REQ-002 SHALL have parameter RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed dbus priority.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 i_ibus_adr/i_ibus_cyc  input  32/1  instruction-fetch master, read-only.
REQ-006 o_ibus_rdt/o_ibus_ack/o_ibus_err  output  32/1/1  ibus read data, ack, error.
REQ-007 i_dbus_adr/i_dbus_dat/i_dbus_sel/i_dbus_we/i_dbus_cyc  input  32/32/4/1/1  data master.
REQ-008 o_dbus_rdt/o_dbus_ack/o_dbus_err  output  32/1/1  dbus read data, ack, error.
REQ-009 o_wb_adr/o_wb_dat/o_wb_sel/o_wb_we/o_wb_cyc/o_wb_stb  output  32/32/4/1/1/1  shared slave port.
REQ-010 i_wb_rdt/i_wb_ack  input  32/1  slave read data, ack.
REQ-011 o_grant  output  2  one-hot current owner: bit0 ibus, bit1 dbus; 00 = idle.

Function
REQ-012 SHALL implement states IDLE, IBUS, DBUS; o_grant SHALL be the one-hot encoding of the state.
REQ-013 In IDLE with exactly one cyc high, next state SHALL be that master's state (grant latency one cycle).
REQ-014 In IDLE with both cyc high: RR_EN=1 grants the master not granted last; RR_EN=0 always grants dbus.
REQ-015 The "last granted" flag SHALL update on every grant; it resets to ibus, so the first contended grant goes to dbus.
REQ-016 o_wb_cyc SHALL equal the owner's cyc ANDed with ownership; o_wb_stb SHALL equal o_wb_cyc.
REQ-017 o_wb_adr/dat/sel/we SHALL be driven from the owner combinationally; in IDLE they SHALL be 0.
REQ-018 The ibus path SHALL drive o_wb_we=0, o_wb_sel=4'b1111, o_wb_dat=0.
REQ-019 o_*_ack SHALL be i_wb_ack & o_wb_cyc, routed only to the owner; o_*_rdt SHALL be i_wb_rdt to both masters.
REQ-020 A cycle with o_wb_cyc & i_wb_ack SHALL return state to IDLE; a new grant is possible at the earliest one cycle later.
REQ-021 If the owner drops cyc without ack (abort), state SHALL return to IDLE next cycle and o_wb_cyc SHALL fall immediately.
REQ-022 i_wb_ack while IDLE SHALL be ignored: no ack forwarded, no state change.
REQ-023 A non-owner's request SHALL be held off until the owner's cycle ends; the arbiter SHALL NOT preempt.

Reset
REQ-024 Assertion of i_rst_n=0 SHALL immediately force IDLE, last-granted=ibus, watchdog=0; all outputs combinationally 0.
REQ-025 Reset mid-transaction SHALL drop o_wb_cyc asynchronously; no ack or err is generated for the aborted cycle.

Configuration
REQ-026 With SERV_ARB_TIMEOUT_EN defined: a TIMEOUT_W-bit counter SHALL clear on IDLE or ack and increment each owned cycle without ack.
REQ-027 On count reaching 2**TIMEOUT_W-1 without ack, the owner's o_*_err SHALL pulse one cycle, o_wb_cyc SHALL drop, state SHALL go IDLE.
REQ-028 Ack and terminal count in the same cycle SHALL be treated as ack; no err.
REQ-029 Without SERV_ARB_TIMEOUT_EN: no counter; o_ibus_err and o_dbus_err tied 0; ports retained.

Structure
REQ-030 A shared package SHALL hold the state encoding constants and grant one-hot constants.
REQ-031 The watchdog SHALL be one sub-module, serv_arb_wdt (clear, count enable, terminal-count output), instantiated only under the macro.
REQ-032 Target 120-400 lines of RTL; no latches; mux and ack routing combinational, state and counters registered.

Verification
REQ-033 ibus-only read, adr=0x100, ack after 3 cycles -> o_grant=01 from cycle 1, one o_ibus_ack, rdt passed, IDLE after ack.
REQ-034 Both request in the same cycle after reset, RR_EN=1 -> dbus first; after both re-request, ibus next; RR_EN=0 -> dbus both times.
REQ-035 dbus write adr=0x200, dat=0xDEADBEEF, sel=0011 while ibus pending -> slave sees exact values, o_ibus_ack stays 0.
REQ-036 dbus drops cyc two cycles into an unacked cycle -> o_wb_cyc falls the same cycle, IDLE next, pending ibus granted next.
REQ-037 Macro on, TIMEOUT_W=4, slave never acks -> o_dbus_err pulses at owned cycle 15, IDLE follows; ack at cycle 15 -> ack only.
REQ-038 i_rst_n low during owned cycle -> o_wb_cyc and o_grant 0 without a clock edge; state IDLE after release.

Source files
------------

// File: rtl/serv_wb_arbiter_pkg.sv
// Shared definitions for the SERV Wishbone arbiter: state encoding and
// one-hot grant constants.
package serv_wb_arbiter_pkg;

    // The state encoding is chosen so that each state value is already the
    // one-hot grant pattern for that owner.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_IBUS = 2'b01,
        ST_DBUS = 2'b10
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IBUS = 2'b01;
    localparam logic [1:0] GRANT_DBUS = 2'b10;

    // Map an arbiter state to its one-hot grant vector.
    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            ST_IBUS: grant_of = GRANT_IBUS;
            ST_DBUS: grant_of = GRANT_DBUS;
            default: grant_of = GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/serv_arb_wdt.sv
// Bus watchdog for the SERV Wishbone arbiter. Counts owned cycles without
// an ack. o_tc flags the cycle whose increment would reach the all-ones
// count, so the caller can end the transfer in that same cycle.
module serv_arb_wdt #(
    parameter int TIMEOUT_W = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [TIMEOUT_W-1:0] TC_PREV = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] count;

    // Counter: clear has priority over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clr) begin
            count <= '0;
        end else if (i_en) begin
            count <= count + 1'b1;
        end
    end

    assign o_tc = i_en && (count == TC_PREV);

endmodule

// File: rtl/serv_wb_arbiter.sv
// Two-master Wishbone arbiter for SERV: instruction bus (read-only) and
// data bus share one slave port. Round-robin or fixed dbus priority.
// Optional bus watchdog enabled by defining SERV_ARB_TIMEOUT_EN.
module serv_wb_arbiter
    import serv_wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_W = 8,
    parameter int RR_EN     = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    output logic        o_ibus_err,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic        o_dbus_err,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic [1:0]  o_grant
);

    arb_state_t state, state_next;
    logic       last_dbus, last_dbus_next;
    logic       own_ibus, own_dbus, owned;
    logic       ack_owned;
    logic       timeout;

    assign own_ibus  = (state == ST_IBUS);
    assign own_dbus  = (state == ST_DBUS);
    assign owned     = own_ibus | own_dbus;

    // Cycle falls the moment the owner drops cyc, without waiting for the FSM.
    assign o_wb_cyc  = (own_ibus & i_ibus_cyc) | (own_dbus & i_dbus_cyc);
    assign o_wb_stb  = o_wb_cyc;
    assign ack_owned = i_wb_ack & o_wb_cyc;

    assign o_ibus_ack = ack_owned & own_ibus;
    assign o_dbus_ack = ack_owned & own_dbus;
    // Read data is broadcast, but held at zero while reset is asserted.
    assign o_ibus_rdt = i_rst_n ? i_wb_rdt : 32'h0;
    assign o_dbus_rdt = i_rst_n ? i_wb_rdt : 32'h0;
    assign o_grant    = grant_of(state);

`ifdef SERV_ARB_TIMEOUT_EN
    logic wdt_tc;

    serv_arb_wdt #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wdt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (~owned | ack_owned),
        .i_en    (owned & ~ack_owned),
        .o_tc    (wdt_tc)
    );

    // An ack in the terminal cycle wins over the timeout.
    assign timeout    = wdt_tc & o_wb_cyc & ~ack_owned;
    assign o_ibus_err = timeout & own_ibus;
    assign o_dbus_err = timeout & own_dbus;
`else
    logic [TIMEOUT_W-1:0] unused_timeout_w;

    assign unused_timeout_w = '0;
    assign timeout          = 1'b0;
    assign o_ibus_err       = 1'b0;
    assign o_dbus_err       = 1'b0;
`endif

    // Slave port mux: drive from the owner, zero when idle.
    always_comb begin
        o_wb_adr = 32'h0;
        o_wb_dat = 32'h0;
        o_wb_sel = 4'h0;
        o_wb_we  = 1'b0;
        if (own_ibus) begin
            o_wb_adr = i_ibus_adr;
            o_wb_sel = 4'b1111;
        end else if (own_dbus) begin
            o_wb_adr = i_dbus_adr;
            o_wb_dat = i_dbus_dat;
            o_wb_sel = i_dbus_sel;
            o_wb_we  = i_dbus_we;
        end
    end

    // Next-state and last-granted logic; owners are never preempted.
    always_comb begin
        state_next     = state;
        last_dbus_next = last_dbus;
        case (state)
            ST_IDLE: begin
                if (i_ibus_cyc && i_dbus_cyc) begin
                    state_next = ((RR_EN != 0) && last_dbus) ? ST_IBUS : ST_DBUS;
                end else if (i_ibus_cyc) begin
                    state_next = ST_IBUS;
                end else if (i_dbus_cyc) begin
                    state_next = ST_DBUS;
                end
                if (state_next == ST_DBUS) begin
                    last_dbus_next = 1'b1;
                end else if (state_next == ST_IBUS) begin
                    last_dbus_next = 1'b0;
                end
            end
            ST_IBUS: begin
                if (!i_ibus_cyc || ack_owned || timeout) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DBUS: begin
                if (!i_dbus_cyc || ack_owned || timeout) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; reset forces idle with ibus as last granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            last_dbus <= 1'b0;
        end else begin
            state     <= state_next;
            last_dbus <= last_dbus_next;
        end
    end

endmodule

// File: tb/tb_serv_wb_arbiter.sv
// Directed testbench for serv_wb_arbiter: one round-robin instance and one
// fixed-priority instance driven by the same masters and slave.
module tb_serv_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] dbus_adr, dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we, dbus_cyc;
    logic [31:0] wb_rdt;
    logic        wb_ack;

    logic [31:0] ibus_rdt, dbus_rdt, wb_adr, wb_dat;
    logic        ibus_ack, ibus_err, dbus_ack, dbus_err;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic [1:0]  grant;

    logic [31:0] fp_ibus_rdt, fp_dbus_rdt, fp_wb_adr, fp_wb_dat;
    logic        fp_ibus_ack, fp_ibus_err, fp_dbus_ack, fp_dbus_err;
    logic [3:0]  fp_wb_sel;
    logic        fp_wb_we, fp_wb_cyc, fp_wb_stb;
    logic [1:0]  fp_grant;

    int checks = 0;
    int errors = 0;

    serv_wb_arbiter #(.TIMEOUT_W(4), .RR_EN(1)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc),
        .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack), .o_ibus_err(ibus_err),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel),
        .i_dbus_we(dbus_we), .i_dbus_cyc(dbus_cyc),
        .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack), .o_dbus_err(dbus_err),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb),
        .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .o_grant(grant)
    );

    serv_wb_arbiter #(.TIMEOUT_W(4), .RR_EN(0)) u_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc),
        .o_ibus_rdt(fp_ibus_rdt), .o_ibus_ack(fp_ibus_ack), .o_ibus_err(fp_ibus_err),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel),
        .i_dbus_we(dbus_we), .i_dbus_cyc(dbus_cyc),
        .o_dbus_rdt(fp_dbus_rdt), .o_dbus_ack(fp_dbus_ack), .o_dbus_err(fp_dbus_err),
        .o_wb_adr(fp_wb_adr), .o_wb_dat(fp_wb_dat), .o_wb_sel(fp_wb_sel), .o_wb_we(fp_wb_we),
        .o_wb_cyc(fp_wb_cyc), .o_wb_stb(fp_wb_stb),
        .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .o_grant(fp_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ibus_adr = 32'h0; ibus_cyc = 1'b0;
        dbus_adr = 32'h0; dbus_dat = 32'h0; dbus_sel = 4'h0;
        dbus_we  = 1'b0;  dbus_cyc = 1'b0;
        wb_rdt   = 32'h0; wb_ack   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        wb_rdt = 32'hA5A5_A5A5;
        rst_n  = 1'b0;
        #3;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b/%b want 0/0", wb_cyc, wb_stb); end
        checks++; if (ibus_rdt !== 32'h0 || dbus_rdt !== 32'h0) begin errors++; $display("FAIL reset_rdt: got %h/%h want 0", ibus_rdt, dbus_rdt); end
        checks++; if (ibus_err !== 1'b0 || dbus_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b/%b want 0/0", ibus_err, dbus_err); end
        tick();
        tick();
        rst_n = 1'b1;
        wb_rdt = 32'h0;
        tick();
    endtask

    task automatic test_ibus_read();
        ibus_adr = 32'h100;
        ibus_cyc = 1'b1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ibus_latency: got %b want 00", grant); end
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ibus_grant: got %b want 01", grant); end
        checks++; if (wb_adr !== 32'h100 || wb_sel !== 4'hF || wb_we !== 1'b0 || wb_dat !== 32'h0)
            begin errors++; $display("FAIL ibus_mux: got adr=%h sel=%h we=%b dat=%h want 100/f/0/0", wb_adr, wb_sel, wb_we, wb_dat); end
        checks++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b1) begin errors++; $display("FAIL ibus_cyc: got %b/%b want 1/1", wb_cyc, wb_stb); end
        tick();
        tick();
        checks++; if (ibus_ack !== 1'b0) begin errors++; $display("FAIL ibus_early_ack: got %b want 0", ibus_ack); end
        wb_ack = 1'b1;
        wb_rdt = 32'h1234_5678;
        #1;
        checks++; if (ibus_ack !== 1'b1 || dbus_ack !== 1'b0) begin errors++; $display("FAIL ibus_ack: got %b/%b want 1/0", ibus_ack, dbus_ack); end
        checks++; if (ibus_rdt !== 32'h1234_5678) begin errors++; $display("FAIL ibus_rdt: got %h want 12345678", ibus_rdt); end
        tick();
        wb_ack = 1'b0;
        ibus_cyc = 1'b0;
        #1;
        checks++; if (grant !== 2'b00 || wb_adr !== 32'h0) begin errors++; $display("FAIL ibus_idle: got %b adr=%h want 00/0", grant, wb_adr); end
    endtask

    task automatic test_round_robin();
        do_reset();
        ibus_adr = 32'h300;
        dbus_adr = 32'h400;
        ibus_cyc = 1'b1;
        dbus_cyc = 1'b1;
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rr_first: got %b want 10", grant); end
        checks++; if (fp_grant !== 2'b10) begin errors++; $display("FAIL fp_first: got %b want 10", fp_grant); end
        checks++; if (wb_adr !== 32'h400) begin errors++; $display("FAIL rr_first_adr: got %h want 400", wb_adr); end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_gap: got %b want 00", grant); end
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_second: got %b want 01", grant); end
        checks++; if (fp_grant !== 2'b10) begin errors++; $display("FAIL fp_second: got %b want 10", fp_grant); end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        ibus_cyc = 1'b0;
        dbus_cyc = 1'b0;
        tick();
    endtask

    task automatic test_dbus_write();
        dbus_adr = 32'h200;
        dbus_dat = 32'hDEAD_BEEF;
        dbus_sel = 4'b0011;
        dbus_we  = 1'b1;
        dbus_cyc = 1'b1;
        tick();
        ibus_adr = 32'h500;
        ibus_cyc = 1'b1;
        #1;
        checks++; if (wb_adr !== 32'h200 || wb_dat !== 32'hDEAD_BEEF || wb_sel !== 4'b0011 || wb_we !== 1'b1)
            begin errors++; $display("FAIL dw_mux: got adr=%h dat=%h sel=%b we=%b want 200/deadbeef/0011/1", wb_adr, wb_dat, wb_sel, wb_we); end
        tick();
        tick();
        checks++; if (grant !== 2'b10 || ibus_ack !== 1'b0) begin errors++; $display("FAIL dw_hold: got %b ack=%b want 10/0", grant, ibus_ack); end
        wb_ack = 1'b1;
        #1;
        checks++; if (dbus_ack !== 1'b1 || ibus_ack !== 1'b0) begin errors++; $display("FAIL dw_ack: got %b/%b want 1/0", dbus_ack, ibus_ack); end
        tick();
        wb_ack = 1'b0;
        dbus_cyc = 1'b0;
        dbus_we = 1'b0;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL dw_idle: got %b want 00", grant); end
        tick();
        checks++; if (grant !== 2'b01 || wb_adr !== 32'h500) begin errors++; $display("FAIL dw_ibus_next: got %b adr=%h want 01/500", grant, wb_adr); end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        ibus_cyc = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        dbus_adr = 32'h600;
        dbus_cyc = 1'b1;
        tick();
        ibus_adr = 32'h700;
        ibus_cyc = 1'b1;
        tick();
        dbus_cyc = 1'b0;
        #1;
        checks++; if (wb_cyc !== 1'b0 || dbus_ack !== 1'b0) begin errors++; $display("FAIL abort_cyc: got %b ack=%b want 0/0", wb_cyc, dbus_ack); end
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL abort_grant: got %b want 10", grant); end
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abort_idle: got %b want 00", grant); end
        tick();
        checks++; if (grant !== 2'b01 || wb_cyc !== 1'b1) begin errors++; $display("FAIL abort_next: got %b cyc=%b want 01/1", grant, wb_cyc); end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        ibus_cyc = 1'b0;
        tick();
    endtask

    task automatic test_idle_ack();
        wb_ack = 1'b1;
        #1;
        checks++; if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0) begin errors++; $display("FAIL idle_ack: got %b/%b want 0/0", ibus_ack, dbus_ack); end
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL idle_ack_state: got %b want 00", grant); end
        wb_ack = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        ibus_adr = 32'h800;
        ibus_cyc = 1'b1;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ar_grant: got %b want 01", grant); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wb_cyc !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL ar_drop: got cyc=%b grant=%b want 0/00", wb_cyc, grant); end
        wb_ack = 1'b1;
        #1;
        checks++; if (ibus_ack !== 1'b0 || ibus_err !== 1'b0) begin errors++; $display("FAIL ar_ack: got %b/%b want 0/0", ibus_ack, ibus_err); end
        wb_ack = 1'b0;
        ibus_cyc = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ar_idle: got %b want 00", grant); end
    endtask

`ifdef SERV_ARB_TIMEOUT_EN
    task automatic test_timeout();
        dbus_adr = 32'h900;
        dbus_cyc = 1'b1;
        tick();
        for (int c = 1; c <= 14; c++) begin
            checks++; if (dbus_err !== 1'b0) begin errors++; $display("FAIL to_early c=%0d: got %b want 0", c, dbus_err); end
            tick();
        end
        checks++; if (dbus_err !== 1'b1 || ibus_err !== 1'b0) begin errors++; $display("FAIL to_err: got %b/%b want 1/0", dbus_err, ibus_err); end
        tick();
        checks++; if (grant !== 2'b00 || dbus_err !== 1'b0) begin errors++; $display("FAIL to_idle: got %b err=%b want 00/0", grant, dbus_err); end
        dbus_cyc = 1'b0;
        tick();
        dbus_cyc = 1'b1;
        tick();
        for (int c = 1; c <= 14; c++) tick();
        wb_ack = 1'b1;
        #1;
        checks++; if (dbus_ack !== 1'b1 || dbus_err !== 1'b0) begin errors++; $display("FAIL to_ack_wins: got ack=%b err=%b want 1/0", dbus_ack, dbus_err); end
        tick();
        wb_ack = 1'b0;
        dbus_cyc = 1'b0;
        tick();
    endtask
`else
    task automatic test_timeout();
        dbus_adr = 32'h900;
        dbus_cyc = 1'b1;
        tick();
        for (int c = 1; c <= 20; c++) begin
            checks++; if (dbus_err !== 1'b0 || grant !== 2'b10) begin errors++; $display("FAIL no_wdt c=%0d: got err=%b grant=%b want 0/10", c, dbus_err, grant); end
            tick();
        end
        dbus_cyc = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_ibus_read();
        test_round_robin();
        test_dbus_write();
        test_abort();
        test_idle_ack();
        test_async_reset();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
